// File: rtl/drum_pkg.sv
// Shared types and constants for the drum strike detector: FSM state encoding,
// Q9 rate constants and the velocity saturation helper.
package drum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWING   = 2'd1,
    ST_REFRACT = 2'd2
  } drum_state_e;

  localparam int GYRO_W        = 16;
  localparam int RATE_W        = 17;
  localparam int VEL_W         = 7;
  localparam int Q9_ONE        = 512;
  localparam int THRESH_ON_Q9  = 5 * Q9_ONE;
  localparam int THRESH_OFF_Q9 = 2 * Q9_ONE;

  localparam logic [VEL_W-1:0] VEL_MAX = 7'd127;

  // Velocity is the scaled peak clamped to 1..127 so a hit never reports zero.
  function automatic logic [VEL_W-1:0] vel_sat(input logic [RATE_W-1:0] peak,
                                               input int shift);
    logic [RATE_W-1:0] scaled;
    scaled = peak >> shift;
    if (scaled == '0) begin
      return VEL_W'(1);
    end else if (scaled > RATE_W'(VEL_MAX)) begin
      return VEL_MAX;
    end else begin
      return scaled[VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/gyro_axis_cond.sv
// Selects one gyro axis and optionally negates it into a 17-bit signed rate,
// so that -32768 maps to +32767 instead of wrapping.
module gyro_axis_cond
  import drum_pkg::*;
#(
  parameter int AXIS   = 1,
  parameter bit INVERT = 1'b1
) (
  input  logic signed [GYRO_W-1:0] gyro_x_i,
  input  logic signed [GYRO_W-1:0] gyro_y_i,
  input  logic signed [GYRO_W-1:0] gyro_z_i,
  output logic signed [RATE_W-1:0] rate_o
);

  logic signed [GYRO_W-1:0] sel;

  always_comb begin
    sel = gyro_y_i;
    case (AXIS)
      0:       sel = gyro_x_i;
      2:       sel = gyro_z_i;
      default: sel = gyro_y_i;
    endcase

    rate_o = {sel[GYRO_W-1], sel};
    if (INVERT) begin
      if (sel == 16'sh8000) begin
        rate_o = 17'sd32767;
      end else begin
        rate_o = -{sel[GYRO_W-1], sel};
      end
    end
  end

endmodule

// File: rtl/drum_strike_detector.sv
// Detects drum strikes from gyro rate on one axis and reports a 1-cycle hit
// with a saturated velocity; includes refractory blanking and a stale-sensor watchdog.
//   state   | meaning
//   IDLE    | waiting for rate >= THRESH_ON
//   SWING   | tracking peak until rate < THRESH_OFF
//   REFRACT | post-hit blanking, samples ignored
module drum_strike_detector
  import drum_pkg::*;
#(
  parameter int AXIS              = 1,
  parameter bit INVERT            = 1'b1,
  parameter int THRESH_ON         = THRESH_ON_Q9,
  parameter int THRESH_OFF        = THRESH_OFF_Q9,
  parameter int VEL_SHIFT         = 7,
  parameter int REFRACT_CYCLES    = 150000,
  parameter int MAX_SWING_SAMPLES = 200,
  parameter int STALE_CYCLES      = 300000
) (
  input  logic                     clk,
  input  logic                     fpga_rst_n,
  input  logic                     enable,
  input  logic                     gyro_valid,
  input  logic signed [GYRO_W-1:0] gyro_x,
  input  logic signed [GYRO_W-1:0] gyro_y,
  input  logic signed [GYRO_W-1:0] gyro_z,
  output logic                     hit_valid,
  output logic [VEL_W-1:0]         hit_velocity,
  output logic [7:0]               hit_count,
  output logic                     swing_active,
  output logic                     sensor_stale,
  output logic [1:0]               state_dbg
);

  localparam int REF_W   = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam int SWING_W = $clog2(MAX_SWING_SAMPLES + 1);

  localparam logic signed [RATE_W-1:0] ON_S  = RATE_W'(THRESH_ON);
  localparam logic signed [RATE_W-1:0] OFF_S = RATE_W'(THRESH_OFF);

  logic signed [RATE_W-1:0] rate;
  drum_state_e              state_q;
  logic signed [RATE_W-1:0] peak_q;
  logic [SWING_W-1:0]       swing_cnt_q;
  logic [REF_W-1:0]         ref_cnt_q;
  logic [STALE_W-1:0]       stale_cnt_q, stale_cnt_d;
  logic                     stale_hit;
  logic                     hit_valid_q;
  logic [VEL_W-1:0]         hit_vel_q;
  logic [7:0]               hit_count_q;

  gyro_axis_cond #(
    .AXIS   (AXIS),
    .INVERT (INVERT)
  ) u_cond (
    .gyro_x_i (gyro_x),
    .gyro_y_i (gyro_y),
    .gyro_z_i (gyro_z),
    .rate_o   (rate)
  );

  assign stale_hit = (stale_cnt_q == STALE_W'(STALE_CYCLES));

  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (gyro_valid) begin
      stale_cnt_d = '0;
    end else if (!stale_hit) begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q     <= ST_IDLE;
      peak_q      <= '0;
      swing_cnt_q <= '0;
      ref_cnt_q   <= '0;
      stale_cnt_q <= '0;
      hit_valid_q <= 1'b0;
      hit_vel_q   <= '0;
      hit_count_q <= '0;
    end else begin
      hit_valid_q <= 1'b0;
      stale_cnt_q <= stale_cnt_d;
      if (!enable) begin
        state_q     <= ST_IDLE;
        peak_q      <= '0;
        swing_cnt_q <= '0;
        ref_cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (gyro_valid && (rate >= ON_S)) begin
              state_q     <= ST_SWING;
              peak_q      <= rate;
              swing_cnt_q <= SWING_W'(1);
            end
          end
          ST_SWING: begin
            if (gyro_valid) begin
              if (rate < OFF_S) begin
                hit_valid_q <= 1'b1;
                hit_vel_q   <= vel_sat(peak_q, VEL_SHIFT);
                hit_count_q <= hit_count_q + 8'd1;
                state_q     <= ST_REFRACT;
                ref_cnt_q   <= '0;
                swing_cnt_q <= '0;
              end else if (swing_cnt_q == SWING_W'(MAX_SWING_SAMPLES)) begin
                state_q     <= ST_IDLE;
                swing_cnt_q <= '0;
              end else begin
                if (rate > peak_q) peak_q <= rate;
                swing_cnt_q <= swing_cnt_q + SWING_W'(1);
              end
            end else if (stale_hit) begin
              // A swing that loses its sensor mid-stroke is discarded.
              state_q     <= ST_IDLE;
              swing_cnt_q <= '0;
            end
          end
          ST_REFRACT: begin
            if (ref_cnt_q == REF_W'(REFRACT_CYCLES - 1)) begin
              state_q <= ST_IDLE;
            end else begin
              ref_cnt_q <= ref_cnt_q + REF_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign hit_valid    = hit_valid_q;
  assign hit_velocity = hit_vel_q;
  assign hit_count    = hit_count_q;
  assign swing_active = (state_q == ST_SWING);
  assign sensor_stale = stale_hit;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Self-checking bench for drum_strike_detector with shortened timers and a
// timestamp-based behavioural model of the strike rules.
module tb_drum_strike_detector;

  localparam int R     = 300;
  localparam int S     = 600;
  localparam int MAXS  = 200;
  localparam int SHIFT = 7;
  localparam int ON    = 2560;
  localparam int OFF   = 1024;

  logic clk = 1'b0;
  logic fpga_rst_n = 1'b0;
  logic enable = 1'b0;
  logic gyro_valid = 1'b0;
  logic signed [15:0] gyro_x = '0;
  logic signed [15:0] gyro_y = '0;
  logic signed [15:0] gyro_z = '0;
  logic       hit_valid;
  logic [6:0] hit_velocity;
  logic [7:0] hit_count;
  logic       swing_active;
  logic       sensor_stale;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 swing, 2 blanked until cycle m_ref_end.
  int cyc, m_last, m_mode, m_peak, m_n, m_vel, m_cnt, m_ref_end, m_hit, m_hi_exp, dut_hi;

  always #5 clk = ~clk;

  drum_strike_detector #(
    .AXIS              (1),
    .INVERT            (1'b1),
    .THRESH_ON         (ON),
    .THRESH_OFF        (OFF),
    .VEL_SHIFT         (SHIFT),
    .REFRACT_CYCLES    (R),
    .MAX_SWING_SAMPLES (MAXS),
    .STALE_CYCLES      (S)
  ) dut (
    .clk          (clk),
    .fpga_rst_n   (fpga_rst_n),
    .enable       (enable),
    .gyro_valid   (gyro_valid),
    .gyro_x       (gyro_x),
    .gyro_y       (gyro_y),
    .gyro_z       (gyro_z),
    .hit_valid    (hit_valid),
    .hit_velocity (hit_velocity),
    .hit_count    (hit_count),
    .swing_active (swing_active),
    .sensor_stale (sensor_stale),
    .state_dbg    (state_dbg)
  );

  task automatic model_reset();
    cyc = 0; m_last = -1; m_mode = 0; m_peak = 0; m_n = 0; m_vel = 0;
    m_cnt = 0; m_ref_end = 0; m_hit = 0; m_hi_exp = 0; dut_hi = 0;
  endtask

  task automatic model_step(input bit en, input bit gv, input int y);
    int r;
    bit stale_prev;
    r = (y == -32768) ? 32767 : -y;
    stale_prev = (cyc - 1 - m_last) >= S;
    m_hit = 0;
    if (!en) begin
      m_mode = 0; m_peak = 0; m_n = 0;
    end else if (m_mode == 0) begin
      if (gv && r >= ON) begin m_mode = 1; m_peak = r; m_n = 1; end
    end else if (m_mode == 1) begin
      if (gv) begin
        if (r < OFF) begin
          m_hit = 1;
          m_vel = m_peak / (1 << SHIFT);
          if (m_vel > 127) m_vel = 127;
          if (m_vel < 1) m_vel = 1;
          m_cnt = (m_cnt + 1) % 256;
          m_mode = 2;
          m_ref_end = cyc + R;
        end else if (m_n == MAXS) begin
          m_mode = 0;
        end else begin
          if (r > m_peak) m_peak = r;
          m_n++;
        end
      end else if (stale_prev) begin
        m_mode = 0;
      end
    end else begin
      if (cyc >= m_ref_end) m_mode = 0;
    end
    if (gv) m_last = cyc;
    m_hi_exp += m_hit;
    cyc++;
  endtask

  function automatic bit exp_stale();
    return (cyc - 1 - m_last) >= S;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(enable, gyro_valid, int'(gyro_y));
    #1;
    dut_hi += int'(hit_valid);
  endtask

  task automatic sample(input int y, input int gap);
    gyro_y = 16'(y);
    gyro_x = 16'($urandom);
    gyro_z = 16'($urandom);
    gyro_valid = 1'b1;
    tick();
    gyro_valid = 1'b0;
    gyro_y = '0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({hit_valid, hit_velocity, hit_count, swing_active, sensor_stale, state_dbg} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {hit_valid, hit_velocity, hit_count, swing_active, sensor_stale, state_dbg});
    end
    model_reset();
    @(negedge clk);
    fpga_rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_saturate();
    sample(-3000, 3);
    sample(-9000, 3);
    sample(-20000, 3);
    sample(-500, 0);
    checks++;
    if (hit_valid !== 1'b1) begin
      errors++; $display("FAIL sat_hit_valid: got %0d expected 1", hit_valid);
    end
    checks++;
    if (hit_velocity !== 7'(m_vel)) begin
      errors++; $display("FAIL sat_velocity: got %0d expected %0d", hit_velocity, m_vel);
    end
    checks++;
    if (hit_count !== 8'(m_cnt)) begin
      errors++; $display("FAIL sat_count: got %0d expected %0d", hit_count, m_cnt);
    end
    tick();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++; $display("FAIL sat_pulse_width: got %0d expected 0", hit_valid);
    end
    repeat (R + 5) tick();
    checks++;
    if (state_dbg !== 2'(m_mode)) begin
      errors++; $display("FAIL sat_refract_exit: got %0d expected %0d", state_dbg, m_mode);
    end
  endtask

  task automatic test_latency();
    sample(-3000, 2);
    sample(-6400, 2);
    sample(-12800, 2);
    checks++;
    if (hit_valid !== 1'b0 || swing_active !== 1'b1) begin
      errors++; $display("FAIL lat_pre_release: got hv=%0d sw=%0d expected hv=0 sw=1", hit_valid, swing_active);
    end
    sample(0, 0);
    checks++;
    if (hit_valid !== 1'b1) begin
      errors++; $display("FAIL lat_rise: got %0d expected 1", hit_valid);
    end
    checks++;
    if (hit_velocity !== 7'(m_vel)) begin
      errors++; $display("FAIL lat_velocity: got %0d expected %0d", hit_velocity, m_vel);
    end
    repeat (4) tick();
    checks++;
    if (dut_hi !== m_hi_exp) begin
      errors++; $display("FAIL lat_pulse_cycles: got %0d expected %0d", dut_hi, m_hi_exp);
    end
    repeat (R + 5) tick();
  endtask

  task automatic test_refract();
    sample(-9000, 2);
    sample(-100, 0);
    repeat (20) tick();
    sample(-9000, 2);
    sample(-100, 2);
    checks++;
    if (hit_count !== 8'(m_cnt) || dut_hi !== m_hi_exp) begin
      errors++; $display("FAIL refract_blank: got count=%0d pulses=%0d expected count=%0d pulses=%0d",
                         hit_count, dut_hi, m_cnt, m_hi_exp);
    end
    checks++;
    if (state_dbg !== 2'(m_mode)) begin
      errors++; $display("FAIL refract_state: got %0d expected %0d", state_dbg, m_mode);
    end
    repeat (R) tick();
    sample(-9000, 2);
    sample(-100, 0);
    checks++;
    if (hit_valid !== 1'b1 || hit_count !== 8'(m_cnt)) begin
      errors++; $display("FAIL refract_second_hit: got hv=%0d count=%0d expected hv=1 count=%0d",
                         hit_valid, hit_count, m_cnt);
    end
    repeat (R + 5) tick();
  endtask

  task automatic test_abort();
    for (int i = 1; i <= 210; i++) begin
      sample(-5000, 2);
      if (i == 201) begin
        checks++;
        if (state_dbg !== 2'(m_mode) || swing_active !== (m_mode == 1)) begin
          errors++; $display("FAIL abort_state: got st=%0d sw=%0d expected st=%0d", state_dbg, swing_active, m_mode);
        end
      end
    end
    checks++;
    if (dut_hi !== m_hi_exp || state_dbg !== 2'(m_mode)) begin
      errors++; $display("FAIL abort_no_hit: got pulses=%0d st=%0d expected pulses=%0d st=%0d",
                         dut_hi, state_dbg, m_hi_exp, m_mode);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_stale();
    sample(-9000, 0);
    checks++;
    if (swing_active !== 1'b1) begin
      errors++; $display("FAIL stale_enter_swing: got %0d expected 1", swing_active);
    end
    repeat (S + 5) tick();
    checks++;
    if (sensor_stale !== exp_stale() || state_dbg !== 2'(m_mode) || dut_hi !== m_hi_exp) begin
      errors++; $display("FAIL stale_timeout: got stale=%0d st=%0d pulses=%0d expected stale=%0d st=%0d pulses=%0d",
                         sensor_stale, state_dbg, dut_hi, exp_stale(), m_mode, m_hi_exp);
    end
    sample(0, 0);
    checks++;
    if (sensor_stale !== exp_stale()) begin
      errors++; $display("FAIL stale_clear: got %0d expected %0d", sensor_stale, exp_stale());
    end
  endtask

  task automatic test_enable();
    sample(-9000, 1);
    enable = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'(m_mode)) begin
      errors++; $display("FAIL en_force_idle: got %0d expected %0d", state_dbg, m_mode);
    end
    sample(-9000, 1);
    sample(-100, 1);
    checks++;
    if (state_dbg !== 2'(m_mode) || hit_count !== 8'(m_cnt) || dut_hi !== m_hi_exp) begin
      errors++; $display("FAIL en_ignore: got st=%0d count=%0d expected st=%0d count=%0d",
                         state_dbg, hit_count, m_mode, m_cnt);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int y;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: y = -int'($urandom_range(2560, 32768));
        1: y = -int'($urandom_range(1024, 2559));
        2: y = -int'($urandom_range(0, 1023));
        default: y = int'($urandom_range(0, 3000));
      endcase
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      sample(y, int'($urandom_range(0, 4)));
      checks++;
      if (state_dbg !== 2'(m_mode)) begin
        errors++; $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, state_dbg, m_mode);
      end
      checks++;
      if (hit_count !== 8'(m_cnt) || hit_velocity !== 7'(m_vel)) begin
        errors++; $display("FAIL rnd_hit[%0d]: got count=%0d vel=%0d expected count=%0d vel=%0d",
                           i, hit_count, hit_velocity, m_cnt, m_vel);
      end
      checks++;
      if (dut_hi !== m_hi_exp) begin
        errors++; $display("FAIL rnd_pulses[%0d]: got %0d expected %0d", i, dut_hi, m_hi_exp);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_extreme_reset();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    sample(-32768, 1);
    sample(0, 0);
    checks++;
    if (hit_valid !== 1'b1 || hit_velocity !== 7'(m_vel)) begin
      errors++; $display("FAIL extreme_vel: got hv=%0d vel=%0d expected hv=1 vel=%0d", hit_valid, hit_velocity, m_vel);
    end
    repeat (R + 5) tick();
    sample(-5000, 1);
    fpga_rst_n = 1'b0;
    #2;
    checks++;
    if ({hit_valid, hit_velocity, hit_count, swing_active, sensor_stale, state_dbg} !== 20'd0) begin
      errors++;
      $display("FAIL midswing_reset: got %h expected 0",
               {hit_valid, hit_velocity, hit_count, swing_active, sensor_stale, state_dbg});
    end
    model_reset();
    @(negedge clk);
    fpga_rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut_hi !== m_hi_exp || state_dbg !== 2'(m_mode)) begin
      errors++; $display("FAIL post_reset: got pulses=%0d st=%0d expected pulses=%0d st=%0d",
                         dut_hi, state_dbg, m_hi_exp, m_mode);
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_latency();
    test_refract();
    test_abort();
    test_stale();
    test_enable();
    test_random();
    test_extreme_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
